// File: rtl/pf_ram_dp_gen.sv
// Parametrised playfield RAM: CPU-side byte-wide read/write port A, video-side
// full-word read port B, and a built-in clear sequencer, all on clk_a.
//
// Ports:
//   clk_a, reset    sole clock; synchronous active-high reset
//   addr_a, din_a   port A word address and write data (same byte to every written lane)
//   ce_a_n, we_a_n  port A lane selects / lane write enables, active-low
//   dout_a          port A registered read data
//   addr_b, rd_b    port B word address and read request
//   dout_b, valid_b port B registered read word (lane 0 in LSBs) and update strobe
//   clr_req, busy   clear-sequence start pulse and in-progress flag
module pf_ram_dp_gen #(
  parameter int unsigned AW             = 8,
  parameter int unsigned LANES          = 4,
  parameter int unsigned DW             = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk_a,
  input  logic                  reset,
  input  logic [AW-1:0]         addr_a,
  input  logic [DW-1:0]         din_a,
  input  logic [LANES-1:0]      ce_a_n,
  input  logic [LANES-1:0]      we_a_n,
  output logic [DW-1:0]         dout_a,
  input  logic [AW-1:0]         addr_b,
  input  logic                  rd_b,
  output logic [LANES*DW-1:0]   dout_b,
  output logic                  valid_b,
  input  logic                  clr_req,
  output logic                  busy
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        clr_addr_q, clr_addr_d;
  logic [DW-1:0]        dout_a_q, dout_a_d;
  logic [LANES*DW-1:0]  dout_b_q, dout_b_d;
  logic                 valid_b_q;

  logic [DW-1:0]        mem_q [LANES][Depth];

  logic                 clearing;
  logic                 rd_a;
  logic [LaneW-1:0]     sel_a;

  assign clearing = (state_q == StClear);
  assign busy     = clearing;
  assign dout_a   = dout_a_q;
  assign dout_b   = dout_b_q;
  assign valid_b  = valid_b_q;

  // A read cycle needs at least one lane selected and no lane writing.
  assign rd_a = (~&ce_a_n) && (&we_a_n);

  // Highest-index selected lane wins: later iterations overwrite earlier ones.
  always_comb begin
    sel_a = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!ce_a_n[i]) sel_a = LaneW'(i);
    end
  end

  // Clear sequencer.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      StClear: begin
        clr_addr_d = clr_addr_q + AW'(1);
        // clr_req is ignored here; the sweep never restarts mid-way.
        if (clr_addr_q == '1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Port A read data.
  always_comb begin
    dout_a_d = dout_a_q;
    if (rd_a) begin
      dout_a_d = clearing ? '0 : mem_q[sel_a][addr_a];
    end
  end

  // Port B read data with write-through bypass from port A.
  always_comb begin
    dout_b_d = dout_b_q;
    if (rd_b) begin
      for (int i = 0; i < LANES; i++) begin
        if (clearing) begin
          dout_b_d[i*DW +: DW] = '0;
        end else if (!we_a_n[i] && (addr_a == addr_b)) begin
          dout_b_d[i*DW +: DW] = din_a;
        end else begin
          dout_b_d[i*DW +: DW] = mem_q[i][addr_b];
        end
      end
    end
  end

  always_ff @(posedge clk_a) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? StClear : StIdle;
      clr_addr_q <= '0;
      dout_a_q   <= '0;
      dout_b_q   <= '0;
      valid_b_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      dout_a_q   <= dout_a_d;
      dout_b_q   <= dout_b_d;
      valid_b_q  <= rd_b;
    end
  end

  // Storage: no reset; contents are defined only by the clear sweep.
  always_ff @(posedge clk_a) begin
    for (int i = 0; i < LANES; i++) begin
      if (clearing && !reset) begin
        mem_q[i][clr_addr_q] <= '0;
      end else if (!clearing && !we_a_n[i]) begin
        mem_q[i][addr_a] <= din_a;
      end
    end
  end

endmodule

// File: doc/pf_ram_dp_gen.md
# pf_ram_dp_gen

Parametrised playfield RAM for the tile/playfield layers: one CPU-side byte-wide read/write port and one video-side full-word read port, both in the `clk_a` domain. It generalises the fixed 256 x 4-lane playfield store in three ways:

- lane count, lane width and depth are parameters;
- port B has a registered read with a valid strobe and write-through bypass;
- a built-in clear sequencer zeroes the whole array after reset or on request.

It sits between the CPU bus decoder and the playfield fetch pipeline.

## Interface

Parameters:
- `AW`, 8, address width; depth = 2^AW words.
- `LANES`, 4, byte lanes per word.
- `DW`, 8, bits per lane.
- `CLEAR_ON_RESET`, 1, if 1 the clear sequence runs automatically on leaving reset.

Ports:
- `clk_a`  in  1  sole clock for both ports and the sequencer.
- `reset`  in  1  synchronous, active-high.
- `addr_a`  in  AW  port A word address.
- `din_a`  in  DW  port A write data, applied to every write-enabled lane.
- `ce_a_n`  in  LANES  port A lane selects, active-low.
- `we_a_n`  in  LANES  port A lane write enables, active-low.
- `dout_a`  out  DW  port A read data, registered.
- `addr_b`  in  AW  port B word address.
- `rd_b`  in  1  port B read request.
- `dout_b`  out  LANES*DW  port B read word, registered; lane 0 in the LSBs.
- `valid_b`  out  1  `dout_b` was updated this cycle.
- `clr_req`  in  1  one-cycle pulse that starts a clear sequence.
- `busy`  out  1  clear sequence in progress.

## Operation

**Storage**
- LANES independent arrays of 2^AW x DW.
- Contents are undefined until the first clear completes.

**State machine** (states IDLE, CLEAR)
- Reset loads CLEAR if `CLEAR_ON_RESET`=1, otherwise IDLE. Reset also sets `clr_addr` to 0.
- IDLE to CLEAR: on `clr_req`=1; `clr_addr` is set to 0.
- In CLEAR, each cycle writes 0 to every lane at `clr_addr`, then `clr_addr` increments.
- CLEAR to IDLE: in the cycle that writes address 2^AW-1.
- `clr_req` while in CLEAR is ignored; the sequence does not restart.
- `busy` = (state == CLEAR), combinational from the state register.

**Port A** (IDLE only)
- Write: every lane i with `we_a_n[i]`=0 gets `din_a` at `addr_a`. `ce_a_n` is not required for writes.
- Read: the cycle is a read when some `ce_a_n` bit is 0 and all `we_a_n` bits are 1. `dout_a` then loads the selected lane's data at `addr_a`.
- Multiple lanes selected on a read: the highest-index lane wins.
- Any other cycle (no lane selected, or any write): `dout_a` holds.

**Port A in CLEAR**
- Writes are dropped.
- A read cycle loads 0 into `dout_a`.

**Port B**
- When `rd_b`=1, `dout_b` loads all lanes at `addr_b`. Otherwise `dout_b` holds.
- In CLEAR, a read loads 0.
- Bypass: if port A writes lane i at `addr_a` == `addr_b` in the same cycle, lane i of `dout_b` takes `din_a`. The other lanes take the stored data.
- `valid_b` = `rd_b` registered; it is asserted in both states.

**Reset values**
- `dout_a`=0, `dout_b`=0, `valid_b`=0.
- `busy`=`CLEAR_ON_RESET` (visible while reset is held).

## Timing

- Port A read latency: 1 cycle (address at edge N, data valid after edge N+1).
- Port A write: committed at the edge. A read of the same address on the next cycle returns the new data.
- Port B latency: 1 cycle. `valid_b` is aligned with the `dout_b` update.
- Clear duration: exactly 2^AW cycles.
  - With `CLEAR_ON_RESET`=1, `busy` falls 2^AW cycles after the first edge with `reset`=0.
  - After `clr_req` at edge N, `busy` rises after N and falls after N+2^AW.
- Reset asserted mid-clear: takes effect at the next edge. The state returns to its reset state and `clr_addr` to 0, so the sequence restarts from address 0.
- The first port A access is accepted in the cycle `busy`=0.
- `clr_req` together with a port A write in IDLE: the write commits, and the clear starts on the following cycle, so it overwrites that word later.
- `addr_a`, `addr_b` are used modulo 2^AW; `clr_addr` wraps to 0 only via restart.

## Test plan

1. **Reset clear.** AW=8, `CLEAR_ON_RESET`=1. Release reset, hold all inputs idle.
   - Required: `busy`=1 for exactly 256 cycles.
   - Then sweep port B across all addresses: `dout_b`=32'h0 everywhere, `valid_b` one cycle after each `rd_b`.
2. **Lane write/read.** Write 8'hA5 to lane 2 at address 8'h3C (`we_a_n`=4'b1011). Read with `ce_a_n`=4'b1011.
   - Required: `dout_a`=8'hA5 one cycle later.
   - Required: port B read of 8'h3C gives 32'h00A50000.
3. **Read priority and hold.** Lane 3 holds 8'h11 and lane 0 holds 8'h22 at address 5. Read with `ce_a_n`=4'b0110.
   - Required: `dout_a`=8'h11.
   - Then drive `ce_a_n`=4'b1111: `dout_a` stays 8'h11.
4. **Bypass.** In one cycle, port A writes 8'h7E to lane 1 at address 9 while `rd_b`=1 with `addr_b`=9 (stored word 32'h00000000).
   - Required: `dout_b`=32'h00007E00 and `valid_b`=1 next cycle.
5. **Runtime clear and write blocking.** Pulse `clr_req`. While `busy`=1, write 8'hFF to address 0.
   - Required: the write is dropped, and a port A read during `busy` returns 0.
   - After 256 cycles `busy`=0; address 0 reads 0 and all previously written data reads 0.
6. **Reset mid-clear.** Assert reset at clear cycle 100 for 2 cycles.
   - Required: `busy` stays 1; it falls exactly 256 cycles after reset is released.
   - Required: `dout_a`=0, `dout_b`=0 and `valid_b`=0 during reset.
